mant_mult_seq: RTL and testbench

//   Iterative radix-2 shift-add multiplier for single-precision significands.

---
 rtl/mant_mult_seq.sv | 113 +++++++++++
 tb/tb_mant_mult_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mant_mult_seq.sv
// rtl/mant_mult_seq.sv - iterative radix-2 shift-add significand multiplier
//
// Purpose: multiplies two (M+1)-bit significands (hidden bit already in the
// MSB) one multiplier bit per clock, returning the 2M+2-bit raw product
// zero-extended to N bits. Latency is fixed at M+1 iterations regardless of
// operand values.
//
// Ports:
//   clk      in   1     rising-edge clock
//   rst_n    in   1     asynchronous active-low reset
//   start    in   1     request, accepted only in IDLE or DONE
//   a_sig    in   M+1   multiplicand significand
//   b_sig    in   M+1   multiplier significand
//   busy     out  1     high while iterating (RUN)
//   done     out  1     one-cycle pulse when product has just been updated
//   product  out  N     {0, a_sig*b_sig}, held until the next completion
module mant_mult_seq #(
  parameter int M = 23,
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M:0]   a_sig,
  input  logic [M:0]   b_sig,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int P  = 2 * M + 2;
  localparam int CW = (M + 1 > 1) ? $clog2(M + 1) : 1;

  localparam logic [CW-1:0] LAST_COUNT = CW'(M);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [P-1:0]  acc_q, acc_d;
  // Multiplicand is pre-shifted one place per iteration, so it always
  // equals a << count; the multiplier shifts right so bit 0 is bit[count].
  logic [P-1:0]  mcand_q, mcand_d;
  logic [M:0]    mplier_q, mplier_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  product_q, product_d;

  logic accept;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          acc_d    = '0;
          mcand_d  = {{(P - M - 1){1'b0}}, a_sig};
          mplier_d = b_sig;
          count_d  = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          // Whole product written at once on the final iteration.
          product_d        = '0;
          product_d[P-1:0] = acc_d;
          state_d          = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mant_mult_seq.sv
// tb/tb_mant_mult_seq.sv - directed self-checking bench for mant_mult_seq
module tb_mant_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] a_sig;
  logic [23:0] b_sig;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int fails;
  int both_high;

  mant_mult_seq #(.M(23), .N(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_sig   (a_sig),
    .b_sig   (b_sig),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together
  always @(negedge clk) begin
    if (rst_n && busy && done) both_high++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for its done pulse.
  task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic [63:0] exp_prod);
    int cyc;
    a_sig = a;
    b_sig = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_sig = ~a;
    b_sig = ~b;
    check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd24);
    check({tag, "_product"}, product, exp_prod);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_product_held"}, product, exp_prod);
  endtask

  initial begin
    int pulses;
    int first_k;
    int second_k;
    logic [63:0] first_p;
    logic [63:0] second_p;

    checks    = 0;
    fails     = 0;
    both_high = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_sig     = '0;
    b_sig     = '0;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("one_x_one", 24'h800000, 24'h800000, 64'h0000_4000_0000_0000);
    run_op("1p5_x_1p5", 24'hC00000, 24'hC00000, 64'h0000_9000_0000_0000);
    run_op("zero_op",   24'h000000, 24'hFFFFFF, 64'h0000_0000_0000_0000);
    run_op("asym",      24'h800001, 24'h800000, 64'h0000_4000_0080_0000);
    run_op("max",       24'hFFFFFF, 24'hFFFFFF, 64'h0000_FFFF_FE00_0001);

    // Reset during iteration 10: everything clears at once, no done follows.
    a_sig = 24'hC00000;
    b_sig = 24'hC00000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_product", product, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("midreset_no_done", 64'(pulses), 64'd0);

    // start during RUN must be ignored.
    a_sig = 24'h800000;
    b_sig = 24'h800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pulses  = 0;
    first_k = 0;
    first_p = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        start = 1'b1;
        a_sig = 24'hFFFFFF;
        b_sig = 24'hFFFFFF;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          first_k = k;
          first_p = product;
        end
      end
    end
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check("busy_start_latency", 64'(first_k), 64'd24);
    check("busy_start_product", first_p, 64'h0000_4000_0000_0000);

    // Back-to-back: start held high, operands changed right after accept.
    a_sig = 24'hC00000;
    b_sig = 24'hC00000;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_sig    = 24'h800000;
    b_sig    = 24'h800000;
    pulses   = 0;
    first_k  = 0;
    second_k = 0;
    first_p  = '0;
    second_p = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          first_k = k;
          first_p = product;
        end else if (pulses == 2) begin
          second_k = k;
          second_p = product;
          start    = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_first_latency", 64'(first_k), 64'd24);
    check("b2b_gap", 64'(second_k - first_k), 64'd25);
    check("b2b_first_product", first_p, 64'h0000_9000_0000_0000);
    check("b2b_second_product", second_p, 64'h0000_4000_0000_0000);
    check("b2b_idle_after", 64'(busy), 64'd0);

    check("busy_done_exclusive", 64'(both_high), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
